// File: rtl/bit_serializer_if.sv
// bit_serializer_if
//   Handshake and serial-stream bundle for bit_serializer.
//   master : word source; drives data_in/valid_in, observes the stream.
//   slave  : the serializer; accepts words and drives the serial outputs.
//   Signals:
//     data_in    [WIDTH]  parallel word, sampled on the handshake edge
//     valid_in   [1]      data_in is valid
//     ready_out  [1]      serializer is IDLE and can accept a word
//     sout       [1]      serial bit, MSB first (feeds downstream din)
//     sout_valid [1]      sout carries a payload or parity bit
//     word_done  [1]      high during the final bit cycle of a word
//     word_count [CNT_W]  completed words, wraps modulo 2^CNT_W
interface bit_serializer_if #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned CNT_W = 16
);
  logic [WIDTH-1:0] data_in;
  logic             valid_in;
  logic             ready_out;
  logic             sout;
  logic             sout_valid;
  logic             word_done;
  logic [CNT_W-1:0] word_count;

  modport master (
    output data_in, valid_in,
    input  ready_out, sout, sout_valid, word_done, word_count
  );

  modport slave (
    input  data_in, valid_in,
    output ready_out, sout, sout_valid, word_done, word_count
  );
endinterface

// File: rtl/bit_serializer.sv
// bit_serializer
//   Parallel-to-serial front end. Accepts WIDTH-bit words over a valid/ready
//   handshake and emits them one bit per clock, MSB first, holding the line
//   at 0 between words. Keeps a running count of completed words.
//   Optional even-parity bit after the LSB when BIT_SERIALIZER_PARITY_EN is
//   defined (adds the PAR state; the port list is unchanged).
//   Ports:
//     clock  : rising-edge clock
//     reset  : asynchronous, active-high reset; aborts any word in flight
//     bus    : bit_serializer_if.slave (data_in/valid_in in;
//              ready_out/sout/sout_valid/word_done/word_count out)
module bit_serializer #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned CNT_W = 16
) (
  input  logic                 clock,
  input  logic                 reset,
  bit_serializer_if.slave      bus
);

  localparam int unsigned CW = $clog2(WIDTH);

`ifdef BIT_SERIALIZER_PARITY_EN
  typedef enum logic [1:0] {IDLE, SHIFT, PAR} state_t;
`else
  typedef enum logic [1:0] {IDLE, SHIFT} state_t;
`endif

  state_t           r_state;
  // The MSB goes straight to r_sout on load, so only the remaining
  // WIDTH-1 bits need to be held for shifting.
  logic [WIDTH-2:0] r_shift;
  logic [CW-1:0]    r_bit_cnt;
  logic             r_sout;
  logic             r_sout_valid;
  logic             r_word_done;
  logic             r_ready;
  logic [CNT_W-1:0] r_word_count;
`ifdef BIT_SERIALIZER_PARITY_EN
  logic             r_parity;
`endif

  logic w_accept;
  logic w_last_bit;

  assign w_accept   = bus.valid_in && r_ready;
  assign w_last_bit = (r_bit_cnt == CW'(WIDTH - 1));

  // Outputs are registered one step ahead: each transition loads the value
  // that the destination state presents during its cycle.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state      <= IDLE;
      r_shift      <= '0;
      r_bit_cnt    <= '0;
      r_sout       <= 1'b0;
      r_sout_valid <= 1'b0;
      r_word_done  <= 1'b0;
      r_ready      <= 1'b1;
      r_word_count <= '0;
`ifdef BIT_SERIALIZER_PARITY_EN
      r_parity     <= 1'b0;
`endif
    end else begin
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_state      <= SHIFT;
            r_shift      <= bus.data_in[WIDTH-2:0];
            r_bit_cnt    <= '0;
            r_sout       <= bus.data_in[WIDTH-1];
            r_sout_valid <= 1'b1;
            r_ready      <= 1'b0;
`ifdef BIT_SERIALIZER_PARITY_EN
            r_parity     <= ^bus.data_in;
            r_word_done  <= 1'b0;
`else
            // A 2-bit word's final bit is the second one; flag it early.
            r_word_done  <= (WIDTH == 2);
`endif
          end
        end

        SHIFT: begin
          r_shift   <= r_shift << 1;
          r_bit_cnt <= r_bit_cnt + 1'b1;
          if (w_last_bit) begin
`ifdef BIT_SERIALIZER_PARITY_EN
            r_state      <= PAR;
            r_sout       <= r_parity;
            r_sout_valid <= 1'b1;
            r_word_done  <= 1'b1;
`else
            r_state      <= IDLE;
            r_sout       <= 1'b0;
            r_sout_valid <= 1'b0;
            r_word_done  <= 1'b0;
            r_ready      <= 1'b1;
            r_word_count <= r_word_count + 1'b1;
`endif
          end else begin
            r_sout       <= r_shift[WIDTH-2];
            r_sout_valid <= 1'b1;
`ifdef BIT_SERIALIZER_PARITY_EN
            r_word_done  <= 1'b0;
`else
            r_word_done  <= (r_bit_cnt == CW'(WIDTH - 2));
`endif
          end
        end

`ifdef BIT_SERIALIZER_PARITY_EN
        PAR: begin
          r_state      <= IDLE;
          r_sout       <= 1'b0;
          r_sout_valid <= 1'b0;
          r_word_done  <= 1'b0;
          r_ready      <= 1'b1;
          r_word_count <= r_word_count + 1'b1;
        end
`endif

        default: begin
          r_state      <= IDLE;
          r_sout       <= 1'b0;
          r_sout_valid <= 1'b0;
          r_word_done  <= 1'b0;
          r_ready      <= 1'b1;
        end
      endcase
    end
  end

  assign bus.ready_out  = r_ready;
  assign bus.sout       = r_sout;
  assign bus.sout_valid = r_sout_valid;
  assign bus.word_done  = r_word_done;
  assign bus.word_count = r_word_count;

endmodule

// File: tb/tb_bit_serializer.sv
// tb_bit_serializer
//   Directed plus randomized bench for bit_serializer. Two instances share
//   the stimulus: a 16-bit-counter instance and a 2-bit-counter instance for
//   wrap-around. Expected streams are built from each word arithmetically.
module tb_bit_serializer;

  localparam int unsigned W = 8;

  logic         clock;
  logic         reset;
  logic [W-1:0] data;
  logic         valid;

  int vectors;
  int miscompares;
  int model_count;

  bit_serializer_if #(.WIDTH(W), .CNT_W(16)) bus ();
  bit_serializer_if #(.WIDTH(W), .CNT_W(2))  bus2 ();

  assign bus.data_in   = data;
  assign bus.valid_in  = valid;
  assign bus2.data_in  = data;
  assign bus2.valid_in = valid;

  bit_serializer #(.WIDTH(W), .CNT_W(16)) u_dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  bit_serializer #(.WIDTH(W), .CNT_W(2)) u_wrap (
    .clock (clock),
    .reset (reset),
    .bus   (bus2)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_counts(input string tag);
    chk({tag, ".count"}, 32'(bus.word_count), 32'(model_count % 65536));
    chk({tag, ".count2"}, 32'(bus2.word_count), 32'(model_count % 4));
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, ".ready"}, 32'(bus.ready_out), 32'd1);
    chk({tag, ".sout"}, 32'(bus.sout), 32'd0);
    chk({tag, ".svalid"}, 32'(bus.sout_valid), 32'd0);
    chk({tag, ".done"}, 32'(bus.word_done), 32'd0);
    chk_counts(tag);
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Sends one word starting from an IDLE cycle. abort_at >= 0 asserts reset
  // in the middle of that bit's cycle. Leaves the bench in the following
  // IDLE cycle (or the first cycle after reset release).
  task automatic send_word(input logic [W-1:0] w, input bit hold_valid, input int abort_at);
    int len;
    logic [W:0] bits;
    len = W;
    for (int k = 0; k < W; k++) bits[k] = (w >> (W - 1 - k)) & 1;
`ifdef BIT_SERIALIZER_PARITY_EN
    len = W + 1;
    bits[W] = ^w;
`else
    bits[W] = 1'b0;
`endif
    data  = w;
    valid = 1'b1;
    chk_idle("pre");
    tick();
    if (!hold_valid) valid = 1'b0;
    for (int k = 0; k < len; k++) begin
      chk($sformatf("bit%0d.sout", k), 32'(bus.sout), 32'(bits[k]));
      chk($sformatf("bit%0d.svalid", k), 32'(bus.sout_valid), 32'd1);
      chk($sformatf("bit%0d.ready", k), 32'(bus.ready_out), 32'd0);
      chk($sformatf("bit%0d.done", k), 32'(bus.word_done), 32'(k == len - 1));
      chk_counts($sformatf("bit%0d", k));
      if (k == abort_at) begin
        valid = 1'b0;
        #2 reset = 1'b1;
        #1;
        model_count = 0;
        chk_idle("abort");
        tick();
        chk_idle("abort_hold");
        reset = 1'b0;
        return;
      end
      tick();
    end
    model_count++;
    chk_idle("post");
  endtask

  task automatic idle_cycles(input int n);
    valid = 1'b0;
    for (int i = 0; i < n; i++) begin
      tick();
      chk_idle("gap");
    end
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    model_count = 0;
    reset = 1'b1;
    valid = 1'b1;
    data  = 8'hA5;

    // Reset held for three cycles with valid_in asserted.
    for (int i = 0; i < 3; i++) begin
      tick();
      chk_idle("reset");
    end
    reset = 1'b0;

    // Handshake on the first edge after release.
    send_word(8'hA5, 1'b0, -1);
    idle_cycles(2);
    send_word(8'h07, 1'b0, -1);

    // Back-to-back with valid_in held high.
    send_word(8'hFF, 1'b1, -1);
    send_word(8'h00, 1'b1, -1);
    idle_cycles(1);

    // Abort during bit 3, then a clean word.
    send_word(8'hF0, 1'b0, 3);
    send_word(8'h81, 1'b0, -1);

    // Wrap-around on the 2-bit counter instance.
    for (int i = 0; i < 5; i++) send_word(8'(8'h11 * i), 1'b0, -1);

    // Randomized words, hold behaviour and gaps.
    for (int i = 0; i < 24; i++) begin
      logic [W-1:0] w;
      bit hv;
      int gap;
      w   = 8'($urandom_range(0, 255));
      hv  = 1'($urandom_range(0, 1));
      gap = int'($urandom_range(0, 2));
      send_word(w, hv, -1);
      if (gap > 0) idle_cycles(gap);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/bit_serializer.md
# bit_serializer

Parallel-to-serial front end that converts WIDTH-bit words, accepted over a valid/ready handshake, into a one-bit-per-clock stream. Its serial output drives the `din` input of the downstream two-state pulse-pairing FSM on the same clock. Between words it holds the line at 0, so the downstream FSM state is unchanged in idle gaps. It also keeps a running count of completed words.

## Interface
- `WIDTH`, default 8: data word width in bits, minimum 2.
- `CNT_W`, default 16: width of the completed-word counter.
- `clock`  in  1: single clock; all state updates on the rising edge.
- `reset`  in  1: asynchronous, active-high reset; one clock; reset is asynchronous and active-high.
- `data_in`  in  WIDTH: parallel word, sampled on the handshake edge.
- `valid_in`  in  1: `data_in` is valid.
- `ready_out`  out  1: block can accept a word; high exactly when the state is IDLE.
- `sout`  out  1: serial bit, MSB first; connects to the downstream `din`.
- `sout_valid`  out  1: `sout` carries a payload or parity bit this cycle.
- `word_done`  out  1: one-cycle pulse, high during the final bit cycle of a word.
- `word_count`  out  CNT_W: number of completed words; wraps modulo 2^CNT_W.

## Operation
- States: IDLE, SHIFT, and PAR (PAR exists only with the macro).
- Reset values:
  - state = IDLE
  - `ready_out` = 1
  - `sout` = 0, `sout_valid` = 0, `word_done` = 0
  - `word_count` = 0
  - shift register = 0, bit counter = 0
- IDLE:
  - `sout` = 0, `sout_valid` = 0.
  - On an edge with `valid_in && ready_out`: load `data_in` into the shift register, clear the bit counter, and go to SHIFT.
  - `valid_in` without `ready_out` has no effect. The source holds `data_in` stable until the handshake.
- SHIFT:
  - `sout` = shift register MSB; `sout_valid` = 1.
  - Each edge shifts left by one (zero fill) and increments the bit counter.
  - When the counter reaches WIDTH-1, the last payload bit is on `sout`. On that edge, go to PAR if the macro is defined, otherwise go to IDLE.
- PAR: `sout` = parity bit, `sout_valid` = 1. The next edge goes to IDLE.
- `word_done` is high during the final cycle of the word: the last payload bit without the macro, the PAR cycle with it.
- `word_count` increments on the edge that ends the `word_done` cycle. All-ones wraps to 0.
- `ready_out` is low in SHIFT and PAR. A `valid_in` arriving during a word waits; it is neither dropped nor queued internally.
- `sout`, `sout_valid`, `word_done`, and `ready_out` are decoded from registered state only. None of them has a combinational path from `data_in` or `valid_in`.
- Reset asserted mid-word aborts the word:
  - all outputs return to reset values immediately;
  - no `word_done` pulse is produced;
  - `word_count` clears.

## Timing
- Handshake at edge T: first payload bit (MSB) is on `sout` during cycle T+1. Bit k appears during cycle T+1+k.
- Word length on the line: WIDTH cycles, or WIDTH+1 with parity.
- At least one IDLE cycle follows every word (`sout` = 0, `ready_out` = 1). The next handshake can occur on the first IDLE edge.
- Maximum throughput: one word per WIDTH+1 cycles, or WIDTH+2 with parity.
- Downstream FSM sees bit k at the same edge it is valid. There is no extra pipeline stage.

## Configuration
- `BIT_SERIALIZER_PARITY_EN`
  - Defined: PAR state is compiled in. One even-parity bit (XOR of all WIDTH payload bits) follows the LSB.
  - Undefined: PAR logic is absent. SHIFT returns directly to IDLE after the LSB.
- The macro does not change the port list.

## Test plan
- Reset check: hold `reset` = 1 for 3 cycles with `valid_in` = 1.
  - Required: `ready_out` = 1, `sout` = 0, `sout_valid` = 0, `word_count` = 0.
  - Release reset: the handshake occurs on the next edge.
- Single word 8'hA5, no macro:
  - `sout` = 1,0,1,0,0,1,0,1 on cycles T+1..T+8, with `sout_valid` = 1.
  - `word_done` high only at T+8; `word_count` = 1 after T+8.
  - Downstream FSM `dout` pulses at the 2nd and 4th ones.
- Parity, macro defined:
  - 8'h07: stream 0,0,0,0,0,1,1,1 followed by parity 1.
  - 8'hA5: parity bit 0.
  - `word_done` is high on the parity cycle.
- Back-to-back: `valid_in` held high with 8'hFF then 8'h00.
  - Exactly one IDLE cycle (`sout` = 0, `sout_valid` = 0) between the words.
  - `ready_out` is low for all 8 bit cycles of each word.
- Abort: assert `reset` during bit 3 of 8'hF0.
  - Outputs clear immediately; no `word_done`; `word_count` = 0.
  - A fresh 8'h81 afterwards serializes cleanly as 1,0,0,0,0,0,0,1.
- Wrap-around with `CNT_W` = 2: send 5 words.
  - `word_count` sequence: 1, 2, 3, 0, 1.
